// File: rtl/issue_scoreboard_ctrl.sv
// Decode-stage issue controller: pending-write scoreboard for long-latency ops,
// RAW/WAW/fence/capacity stall detection, stall statistics and illegal-writeback flag.
module issue_scoreboard_ctrl #(
    parameter int NUM_REGS        = 32,
    parameter int ADDR_W          = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic              rs1_used_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              rs2_used_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_we_i,
    input  logic              long_lat_i,
    input  logic              fence_i,
    input  logic              flush_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    output logic              stall_o,
    output logic [1:0]        stall_reason_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [OUT_W-1:0]  outstanding_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZARD = 2'd1,
        ST_FENCE  = 2'd2,
        ST_FULL   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 err_q, err_d;

    logic raw, waw, fence_blk, full_blk, blocked;
    logic fire, set_en, clr_en, wb_bad;

    // Hazards look only at registered scoreboard state: a writeback never
    // bypasses into the same-cycle hazard check.
    assign raw = (rs1_used_i && rs1_addr_i != '0 && pending_q[rs1_addr_i]) ||
                 (rs2_used_i && rs2_addr_i != '0 && pending_q[rs2_addr_i]);
    assign waw       = rd_we_i && rd_addr_i != '0 && pending_q[rd_addr_i];
    assign fence_blk = fence_i && outstanding_q != '0;
    assign full_blk  = rd_we_i && long_lat_i && rd_addr_i != '0 &&
                       outstanding_q == OUT_W'(MAX_OUTSTANDING);
    assign blocked   = raw || waw || fence_blk || full_blk;

    assign issue_valid_o = instr_valid_i && !flush_i && !blocked;
    assign instr_ready_o = flush_i || (issue_ready_i && !blocked);
    assign fire          = issue_valid_o && issue_ready_i;

    assign set_en = fire && rd_we_i && long_lat_i && rd_addr_i != '0;
    assign clr_en = wb_valid_i && pending_q[wb_addr_i];
    assign wb_bad = wb_valid_i && !pending_q[wb_addr_i];

    // x0 is hard-wired non-pending; elsewhere a set in the same cycle beats a clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit, clr_hit;
                assign set_hit = set_en && rd_addr_i == ADDR_W'(gi);
                assign clr_hit = clr_en && wb_addr_i == ADDR_W'(gi);
                assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
            end
        end
    endgenerate

    always_comb begin
        outstanding_d = outstanding_q;
        case ({set_en, clr_en})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        state_d     = ST_RUN;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q || wb_bad;
        if (instr_valid_i && !flush_i && blocked) begin
            if (fence_blk)     state_d = ST_FENCE;
            else if (full_blk) state_d = ST_FULL;
            else               state_d = ST_HAZARD;
        end
        if (state_d != ST_RUN && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            err_q         <= err_d;
        end
    end

    assign stall_o        = state_q != ST_RUN;
    assign stall_reason_o = state_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign outstanding_o  = outstanding_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against a set-based reference model.
module tb_issue_scoreboard_ctrl;

    localparam int AW = 5;
    localparam int MAXO = 4;
    localparam int OW = $clog2(MAXO) + 1;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic instr_valid_i, instr_ready_o;
    logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i, wb_addr_i;
    logic rs1_used_i, rs2_used_i, rd_we_i, long_lat_i, fence_i, flush_i;
    logic issue_valid_o, issue_ready_i, wb_valid_i;
    logic stall_o;
    logic [1:0] stall_reason_o;
    logic [CW-1:0] stall_cnt_o;
    logic [OW-1:0] outstanding_o;
    logic err_o;

    always #5 clk = ~clk;

    issue_scoreboard_ctrl #(.NUM_REGS(32), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs1_used_i(rs1_used_i),
        .rs2_addr_i(rs2_addr_i), .rs2_used_i(rs2_used_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .long_lat_i(long_lat_i),
        .fence_i(fence_i), .flush_i(flush_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
        .stall_o(stall_o), .stall_reason_o(stall_reason_o), .stall_cnt_o(stall_cnt_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int v, rs1, u1, rs2, u2, rd, we, ll, fe, fl, ir, wbv, wba;
        int e_iv, e_rdy, e_st, e_rsn, e_out, e_cnt, e_err;
    } vec_t;

    vec_t tbl[24];

    task automatic drive(int v, int rs1, int u1, int rs2, int u2, int rd, int we, int ll,
                         int fe, int fl, int ir, int wbv, int wba);
        instr_valid_i = v[0];
        rs1_addr_i = AW'(rs1); rs1_used_i = u1[0];
        rs2_addr_i = AW'(rs2); rs2_used_i = u2[0];
        rd_addr_i = AW'(rd);   rd_we_i = we[0];    long_lat_i = ll[0];
        fence_i = fe[0];       flush_i = fl[0];    issue_ready_i = ir[0];
        wb_valid_i = wbv[0];   wb_addr_i = AW'(wba);
    endtask

    // Drive a cycle's inputs just after the rising edge, return at the falling edge.
    task automatic step(int v, int rs1, int u1, int rs2, int u2, int rd, int we, int ll,
                        int fe, int fl, int ir, int wbv, int wba);
        @(posedge clk);
        #1;
        drive(v, rs1, u1, rs2, u2, rd, we, ll, fe, fl, ir, wbv, wba);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    // Reference model: the scoreboard is a set of pending registers;
    // the in-flight count is simply its size.
    bit  m_pend[32];
    int  m_state;
    longint m_cnt;
    bit  m_err;

    function automatic int m_out();
        int n = 0;
        for (int r = 0; r < 32; r++) n += m_pend[r];
        return n;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_state = 0; m_cnt = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare DUT against model for the current inputs, then advance the model.
    task automatic model_check();
        bit raw, waw, fb, fu, blk, iv, rdy, fire;
        int nst;
        int rs1 = int'(rs1_addr_i), rs2 = int'(rs2_addr_i);
        int rd = int'(rd_addr_i), wa = int'(wb_addr_i);
        raw = (rs1_used_i && rs1 != 0 && m_pend[rs1]) || (rs2_used_i && rs2 != 0 && m_pend[rs2]);
        waw = rd_we_i && rd != 0 && m_pend[rd];
        fb  = fence_i && m_out() != 0;
        fu  = rd_we_i && long_lat_i && rd != 0 && m_out() == MAXO;
        blk = raw || waw || fb || fu;
        iv  = instr_valid_i && !flush_i && !blk;
        rdy = flush_i || (issue_ready_i && !blk);
        fire = iv && issue_ready_i;
        chk("rnd_issue_valid", issue_valid_o, iv);
        chk("rnd_instr_ready", instr_ready_o, rdy);
        chk("rnd_stall", stall_o, m_state != 0);
        chk("rnd_reason", stall_reason_o, m_state);
        chk("rnd_outstanding", outstanding_o, m_out());
        chk("rnd_stall_cnt", stall_cnt_o, m_cnt);
        chk("rnd_err", err_o, m_err);
        nst = 0;
        if (instr_valid_i && !flush_i && blk) nst = fb ? 2 : (fu ? 1 * 3 : 1);
        if (wb_valid_i) begin
            if (m_pend[wa]) m_pend[wa] = 0;
            else m_err = 1;
        end
        if (fire && rd_we_i && long_lat_i && rd != 0) m_pend[rd] = 1;
        if (nst != 0 && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        m_state = nst;
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0,5,1,1,0,0,1,0,0,  1,1,0,0,0,0,0};
        tbl[1]  = '{1,5,1,0,0,6,1,0,0,0,1,0,0,  0,0,0,0,1,0,0};
        tbl[2]  = '{1,5,1,0,0,6,1,0,0,0,1,0,0,  0,0,1,1,1,1,0};
        tbl[3]  = '{1,5,1,0,0,6,1,0,0,0,1,1,5,  0,0,1,1,1,2,0};
        tbl[4]  = '{1,5,1,0,0,6,1,0,0,0,1,0,0,  1,1,1,1,0,3,0};
        tbl[5]  = '{0,0,0,0,0,0,0,0,0,0,1,0,0,  0,1,0,0,0,3,0};
        tbl[6]  = '{1,0,0,0,0,1,1,1,0,0,1,0,0,  1,1,0,0,0,3,0};
        tbl[7]  = '{1,0,0,0,0,2,1,1,0,0,1,0,0,  1,1,0,0,1,3,0};
        tbl[8]  = '{1,0,0,0,0,3,1,1,0,0,1,0,0,  1,1,0,0,2,3,0};
        tbl[9]  = '{1,0,0,0,0,4,1,1,0,0,1,0,0,  1,1,0,0,3,3,0};
        tbl[10] = '{1,0,0,0,0,6,1,1,0,0,1,0,0,  0,0,0,0,4,3,0};
        tbl[11] = '{1,0,0,0,0,6,1,1,0,0,1,1,1,  0,0,1,3,4,4,0};
        tbl[12] = '{1,0,0,0,0,6,1,1,0,0,1,0,0,  1,1,1,3,3,5,0};
        tbl[13] = '{1,0,0,0,0,0,0,0,1,0,1,1,2,  0,0,0,0,4,5,0};
        tbl[14] = '{1,0,0,0,0,0,0,0,1,0,1,1,3,  0,0,1,2,3,6,0};
        tbl[15] = '{1,0,0,0,0,0,0,0,1,0,1,1,4,  0,0,1,2,2,7,0};
        tbl[16] = '{1,0,0,0,0,0,0,0,1,0,1,1,6,  0,0,1,2,1,8,0};
        tbl[17] = '{1,0,0,0,0,0,0,0,1,0,1,0,0,  1,1,1,2,0,9,0};
        tbl[18] = '{1,0,0,0,0,0,0,0,1,0,1,0,0,  1,1,0,0,0,9,0};
        tbl[19] = '{1,0,0,0,0,0,1,1,0,0,1,0,0,  1,1,0,0,0,9,0};
        tbl[20] = '{0,0,0,0,0,0,0,0,0,0,1,1,0,  0,1,0,0,0,9,0};
        tbl[21] = '{0,0,0,0,0,0,0,0,0,0,1,0,0,  0,1,0,0,0,9,1};
        tbl[22] = '{1,0,0,0,0,9,1,1,0,0,0,0,0,  1,0,0,0,0,9,1};
        tbl[23] = '{1,0,0,0,0,9,1,1,0,1,0,0,0,  0,1,0,0,0,9,1};

        do_reset();
        chk("reset_stall", stall_o, 0);
        chk("reset_reason", stall_reason_o, 0);
        chk("reset_cnt", stall_cnt_o, 0);
        chk("reset_out", outstanding_o, 0);
        chk("reset_err", err_o, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].we,
                 tbl[i].ll, tbl[i].fe, tbl[i].fl, tbl[i].ir, tbl[i].wbv, tbl[i].wba);
            chk($sformatf("vec%0d_issue_valid", i), issue_valid_o, tbl[i].e_iv);
            chk($sformatf("vec%0d_instr_ready", i), instr_ready_o, tbl[i].e_rdy);
            chk($sformatf("vec%0d_stall", i), stall_o, tbl[i].e_st);
            chk($sformatf("vec%0d_reason", i), stall_reason_o, tbl[i].e_rsn);
            chk($sformatf("vec%0d_outstanding", i), outstanding_o, tbl[i].e_out);
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt_o, tbl[i].e_cnt);
            chk($sformatf("vec%0d_err", i), err_o, tbl[i].e_err);
            $display("[TB] vec %0d: iv=%0d rdy=%0d reason=%0d out=%0d cnt=%0d err=%0d",
                     i, issue_valid_o, instr_ready_o, stall_reason_o, outstanding_o, stall_cnt_o, err_o);
        end
        idle();
        chk("err_sticky", err_o, 1);

        // Issue to x8 while x7 writes back in the same cycle: count stays put.
        do_reset();
        step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0);
        chk("same_cyc_issue7", issue_valid_o, 1);
        step(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, 1, 7);
        chk("same_cyc_issue8", issue_valid_o, 1);
        chk("same_cyc_out_before", outstanding_o, 1);
        step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0);
        chk("same_cyc_out_after", outstanding_o, 1);
        chk("same_cyc_reader_x8_held", issue_valid_o, 0);
        // WAW on x8 with a same-cycle x8 writeback: still held (no bypass).
        step(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, 1, 8);
        chk("waw_wb_same_cycle_held", issue_valid_o, 0);
        chk("waw_wb_reason", stall_reason_o, 1);
        step(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, 0, 0);
        chk("waw_next_cycle_issue", issue_valid_o, 1);
        chk("waw_next_cycle_out", outstanding_o, 0);
        idle();
        chk("waw_after_out", outstanding_o, 1);
        $display("[TB] same-cycle/WAW sequence done");

        // Flush during a hazard stall drops the instruction but keeps the scoreboard.
        do_reset();
        step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("flush_pre_held", issue_valid_o, 0);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("flush_ready", instr_ready_o, 1);
        chk("flush_valid", issue_valid_o, 0);
        chk("flush_stall_seen", stall_o, 1);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("flush_state_run", stall_o, 0);
        chk("flush_pending_kept", issue_valid_o, 0);
        chk("flush_out_kept", outstanding_o, 1);
        $display("[TB] flush sequence done");

        // Asynchronous reset in the middle of a stall.
        do_reset();
        step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("async_pre_stall", stall_o, 1);
        chk("async_pre_cnt", stall_cnt_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_stall", stall_o, 0);
        chk("async_reason", stall_reason_o, 0);
        chk("async_cnt", stall_cnt_o, 0);
        chk("async_out", outstanding_o, 0);
        chk("async_issue_unblocked", issue_valid_o, 1);
        $display("[TB] async reset sequence done");

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int wbv, wba, pick;
            int cand[$];
            cand = {};
            for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
            wbv = 0; wba = 0;
            if (cand.size() != 0 && $urandom_range(0, 99) < 40) begin
                pick = $urandom_range(0, cand.size() - 1);
                wbv = 1; wba = cand[pick];
            end else if ($urandom_range(0, 99) < 2) begin
                wbv = 1; wba = $urandom_range(0, 7);
            end
            step($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 99) < 70, $urandom_range(0, 1),
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 80, wbv, wba);
            model_check();
            if (c % 100 == 0)
                $display("[TB] rnd %0d: out=%0d reason=%0d cnt=%0d", c, outstanding_o, stall_reason_o, stall_cnt_o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
